// File: rtl/tp_pkg.sv
// Shared definitions for the tracklet processing controller:
// default widths, the bank-extended address width and the FSM encoding.
package tp_pkg;

   localparam int TP_CNT_W  = 8;
   localparam int TP_RD_LAT = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Address is {bank, idx}: one ping-pong bank bit above the index.
   function automatic int tp_addr_w(input int cnt_w);
      return cnt_w + 1;
   endfunction

endpackage

// File: rtl/tp_tracklet_proc_ctrl_if.sv
// Control/handshake bundle between the start machine, the tracklet memory,
// the downstream consumer and the processing controller.
interface tp_tracklet_proc_ctrl_if
   import tp_pkg::*;
#(
   parameter int CNT_W = TP_CNT_W
);
   localparam int ADDR_W = tp_addr_w(CNT_W);

   logic              cntr_ld_en;
   logic              start_proc;
   logic [CNT_W-1:0]  cnt_in;
   logic              dn_afull;
   logic              proc_bsy;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic              trk_vld;
   logic              trk_last;
   logic              cross_done;
   logic              cross_empty;
   logic              ovr_err;

   modport master (
      output cntr_ld_en, start_proc, cnt_in, dn_afull,
      input  proc_bsy, mem_rd_en, mem_rd_addr, trk_vld, trk_last,
             cross_done, cross_empty, ovr_err
   );

   modport slave (
      input  cntr_ld_en, start_proc, cnt_in, dn_afull,
      output proc_bsy, mem_rd_en, mem_rd_addr, trk_vld, trk_last,
             cross_done, cross_empty, ovr_err
   );

endinterface

// File: rtl/tp_vld_delay.sv
// RD_LAT-stage shift register carrying {vld,last} alongside the tracklet
// memory read data, with asynchronous clear.
module tp_vld_delay #(
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic res,
   input  logic vld_in,
   input  logic last_in,
   output logic vld_out,
   output logic last_out,
   output logic empty
);

   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [RD_LAT-1:0] last_q, last_d;

   assign vld_d[0]  = vld_in;
   assign last_d[0] = last_in;

   for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
      assign vld_d[gi]  = vld_q[gi-1];
      assign last_d[gi] = last_q[gi-1];
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         vld_q  <= '0;
         last_q <= '0;
      end else begin
         vld_q  <= vld_d;
         last_q <= last_d;
      end
   end

   assign vld_out  = vld_q[RD_LAT-1];
   assign last_out = last_q[RD_LAT-1];
   // Nothing left to emerge after the valid currently on the output.
   assign empty    = ~|vld_d;

endmodule

// File: rtl/tp_tracklet_proc_ctrl.sv
// Processing-side controller: walks one crossing's tracklet buffer, issues
// throttled memory reads and reports busy/done back to the start machine.
module tp_tracklet_proc_ctrl
   import tp_pkg::*;
#(
   parameter int CNT_W  = TP_CNT_W,
   parameter int RD_LAT = TP_RD_LAT
) (
   input  logic clk,
   input  logic res,
   tp_tracklet_proc_ctrl_if.slave bus
);

   localparam int ADDR_W = tp_addr_w(CNT_W);

   logic [1:0]        state_q, state_d;
   logic              bank_q, bank_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rd_en_q, rd_en_d;
   logic              rd_last_q, rd_last_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              done_q, done_d;
   logic              empty_q, empty_d;
   logic              bsy_q, bsy_d;
   logic              err_q, err_d;
   logic              dl_empty;
   logic              finish;
   logic              trk_vld;
   logic              trk_last;

   tp_vld_delay #(.RD_LAT(RD_LAT)) u_vld_delay (
      .clk      (clk),
      .res      (res),
      .vld_in   (rd_en_q),
      .last_in  (rd_last_q),
      .vld_out  (trk_vld),
      .last_out (trk_last),
      .empty    (dl_empty)
   );

   always_comb begin
      state_d   = state_q;
      bank_d    = bank_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      rd_addr_d = rd_addr_q;
      err_d     = err_q;
      rd_en_d   = 1'b0;
      rd_last_d = 1'b0;
      done_d    = 1'b0;
      empty_d   = 1'b0;
      finish    = 1'b0;

      if ((bus.start_proc || bus.cntr_ld_en) && (bsy_q || state_q != ST_IDLE))
         err_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (bus.cntr_ld_en)
               cnt_d = bus.cnt_in;
            if (bus.start_proc)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            // An empty crossing finishes straight from RUN to meet the T+2 done.
            if (idx_q == cnt_q) begin
               if (dl_empty)
                  finish = 1'b1;
               else
                  state_d = ST_DRAIN;
            end else if (!bus.dn_afull) begin
               rd_en_d   = 1'b1;
               rd_addr_d = {bank_q, idx_q};
               rd_last_d = (idx_q == cnt_q - CNT_W'(1));
               idx_d     = idx_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (dl_empty)
               finish = 1'b1;
         end
         default: begin
            bank_d  = ~bank_q;
            idx_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      if (finish) begin
         state_d = ST_DONE;
         done_d  = 1'b1;
         empty_d = (cnt_q == '0);
      end

      bsy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q   <= ST_IDLE;
         bank_q    <= 1'b0;
         idx_q     <= '0;
         cnt_q     <= '0;
         rd_en_q   <= 1'b0;
         rd_last_q <= 1'b0;
         rd_addr_q <= '0;
         done_q    <= 1'b0;
         empty_q   <= 1'b0;
         bsy_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bank_q    <= bank_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         rd_en_q   <= rd_en_d;
         rd_last_q <= rd_last_d;
         rd_addr_q <= rd_addr_d;
         done_q    <= done_d;
         empty_q   <= empty_d;
         bsy_q     <= bsy_d;
         err_q     <= err_d;
      end
   end

   assign bus.proc_bsy    = bsy_q;
   assign bus.mem_rd_en   = rd_en_q;
   assign bus.mem_rd_addr = rd_addr_q;
   assign bus.trk_vld     = trk_vld;
   assign bus.trk_last    = trk_last;
   assign bus.cross_done  = done_q;
   assign bus.cross_empty = empty_q;
   assign bus.ovr_err     = err_q;

endmodule

// File: tb/tb_tp_tracklet_proc_ctrl.sv
// Self-checking bench: per-cycle expected outputs are derived from each
// crossing's count and the dn_afull trace, then compared every cycle.
module tb_tp_tracklet_proc_ctrl;
   import tp_pkg::*;

   localparam int CNT_W  = TP_CNT_W;
   localparam int RD_LAT = TP_RD_LAT;
   localparam int ADDR_W = CNT_W + 1;
   localparam int MAXC   = 8192;
   localparam int BIG    = 1 << 30;

   logic clk = 1'b0;
   logic res = 1'b1;

   tp_tracklet_proc_ctrl_if #(.CNT_W(CNT_W)) bus ();

   tp_tracklet_proc_ctrl #(.CNT_W(CNT_W), .RD_LAT(RD_LAT)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc;
   int n_checks;
   int n_errors;
   int err_from;
   int last_done;
   bit bank_m;

   bit afull_pat [MAXC];
   bit exp_bsy   [MAXC];
   bit exp_rd    [MAXC];
   bit exp_vld   [MAXC];
   bit exp_last  [MAXC];
   bit exp_done  [MAXC];
   bit exp_empty [MAXC];
   logic [ADDR_W-1:0] exp_addr [MAXC];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
         if (n_errors >= 40) begin
            $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
            $finish;
         end
      end
   endtask

   task automatic check_cycle();
      check("proc_bsy",    bus.proc_bsy,    exp_bsy[cyc]);
      check("mem_rd_en",   bus.mem_rd_en,   exp_rd[cyc]);
      if (exp_rd[cyc])
         check("mem_rd_addr", bus.mem_rd_addr, exp_addr[cyc]);
      check("trk_vld",     bus.trk_vld,     exp_vld[cyc]);
      check("trk_last",    bus.trk_last,    exp_last[cyc]);
      check("cross_done",  bus.cross_done,  exp_done[cyc]);
      check("cross_empty", bus.cross_empty, exp_empty[cyc]);
      check("ovr_err",     bus.ovr_err,     (cyc > err_from));
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= MAXC - 64) begin
         n_errors++;
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 64);
         $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
         $finish;
      end
      bus.start_proc = 1'b0;
      bus.cntr_ld_en = 1'b0;
      bus.cnt_in     = CNT_W'($urandom);
      bus.dn_afull   = afull_pat[cyc];
   endtask

   // Read k goes out on the k-th non-stalled cycle after start, visible one cycle later.
   task automatic plan(input int t, input int n);
      int c, k, last_vis;
      c = t + 1;
      k = 0;
      last_vis = t;
      while (k < n && c < MAXC - RD_LAT - 8) begin
         if (!afull_pat[c]) begin
            exp_rd[c+1]          = 1'b1;
            exp_addr[c+1]        = {bank_m, k[CNT_W-1:0]};
            exp_vld[c+1+RD_LAT]  = 1'b1;
            exp_last[c+1+RD_LAT] = (k == n - 1);
            last_vis = c + 1;
            k++;
         end
         c++;
      end
      last_done = (n == 0) ? t + 2 : last_vis + RD_LAT + 1;
      exp_done[last_done]  = 1'b1;
      exp_empty[last_done] = (n == 0);
      for (int i = t + 1; i <= last_done; i++)
         exp_bsy[i] = 1'b1;
      bank_m = ~bank_m;
   endtask

   task automatic do_reset();
      @(negedge clk);
      check_cycle();
      #2 res = 1'b1;
      #1;
      check("rst_proc_bsy",    bus.proc_bsy,    0);
      check("rst_mem_rd_en",   bus.mem_rd_en,   0);
      check("rst_mem_rd_addr", bus.mem_rd_addr, 0);
      check("rst_trk_vld",     bus.trk_vld,     0);
      check("rst_trk_last",    bus.trk_last,    0);
      check("rst_cross_done",  bus.cross_done,  0);
      check("rst_cross_empty", bus.cross_empty, 0);
      check("rst_ovr_err",     bus.ovr_err,     0);
      @(posedge clk);
      #1;
      cyc++;
      res = 1'b0;
      for (int c = cyc; c < MAXC; c++) begin
         exp_bsy[c] = 0; exp_rd[c] = 0; exp_vld[c] = 0;
         exp_last[c] = 0; exp_done[c] = 0; exp_empty[c] = 0;
      end
      bank_m    = 1'b0;
      err_from  = BIG;
      last_done = cyc - 1;
      bus.start_proc = 1'b0;
      bus.cntr_ld_en = 1'b0;
      bus.dn_afull   = afull_pat[cyc];
      repeat (RD_LAT + 3) step();
   endtask

   // stall: 0 none, 1 random trace, 2 three-cycle stall after the second read.
   // err_kind: 0 none, 1 start in busy, 2 load on done cycle, 3 load in busy.
   task automatic crossing(input int n, input bit sep, input int stall,
                           input int err_kind, input int rst_off);
      int t, e;
      while (cyc <= last_done) step();
      if (sep) begin
         bus.cntr_ld_en = 1'b1;
         bus.cnt_in     = CNT_W'(n);
         step();
         repeat ($urandom_range(0, 2)) step();
      end
      t = cyc;
      if (stall != 1)
         for (int c = t; c < t + n + RD_LAT + 16; c++) afull_pat[c] = 1'b0;
      if (stall == 2)
         for (int c = t + 3; c <= t + 5; c++) afull_pat[c] = 1'b1;
      bus.dn_afull   = afull_pat[cyc];
      bus.start_proc = 1'b1;
      bus.cntr_ld_en = !sep;
      bus.cnt_in     = sep ? CNT_W'($urandom) : CNT_W'(n);
      $display("crossing t=%0d n=%0d bank=%0d sep=%0d stall=%0d err=%0d rst=%0d",
               t, n, bank_m, sep, stall, err_kind, rst_off);
      plan(t, n);
      e = (err_kind == 2) ? last_done : $urandom_range(t + 1, last_done);
      step();
      while (cyc <= last_done) begin
         if (err_kind != 0 && cyc == e) begin
            if (err_kind == 1) begin
               bus.start_proc = 1'b1;
            end else begin
               bus.cntr_ld_en = 1'b1;
               bus.cnt_in     = CNT_W'($urandom);
            end
            if (err_from > e) err_from = e;
         end
         if (rst_off != 0 && cyc == t + rst_off) begin
            do_reset();
            break;
         end
         step();
      end
   endtask

   initial begin
      #(MAXC * 10 * 2);
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; n_checks = 0; n_errors = 0;
      err_from = BIG; last_done = -1; bank_m = 1'b0;
      for (int c = 0; c < MAXC; c++) afull_pat[c] = ($urandom_range(0, 99) < 30);
      bus.start_proc = 1'b0;
      bus.cntr_ld_en = 1'b0;
      bus.cnt_in     = '0;
      bus.dn_afull   = 1'b0;
      repeat (3) step();
      res = 1'b0;

      crossing(3,   0, 0, 0, 0);
      crossing(0,   0, 0, 0, 0);
      crossing(2,   0, 0, 0, 0);
      crossing(1,   0, 0, 0, 0);
      crossing(1,   0, 0, 0, 0);
      crossing(4,   0, 2, 0, 0);
      crossing(255, 1, 0, 0, 0);
      crossing(0,   1, 1, 0, 0);
      crossing(2,   0, 0, 2, 0);
      crossing(6,   0, 0, 0, 5);
      crossing(3,   0, 0, 3, 0);
      crossing(5,   1, 1, 1, 0);
      crossing(4,   0, 1, 0, 4);

      for (int i = 0; i < 40; i++) begin
         int n, ek;
         n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
         ek = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
         repeat ($urandom_range(0, 2)) step();
         crossing(n, 1'($urandom_range(0, 1)), 1, ek, 0);
      end
      while (cyc <= last_done + 2) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tp_tracklet_proc_ctrl.md
Name: tp_tracklet_proc_ctrl

Overview:
- Processing-side controller directly downstream of the start-new-crossing state machine.
- Consumes its `cntr_ld_en`/`start_proc` pulses and the tracklet count read from the input FIFO.
- Walks the tracklet buffer for the crossing and issues one memory read per tracklet, throttled by downstream almost-full.
- Drives `proc_bsy` back to the start machine, so a new crossing is only launched once the current one is fully drained.

Parameters:
- `CNT_W`, 8, width of the tracklet count and of the per-crossing index.
- `RD_LAT`, 2, tracklet memory read latency in cycles (≥1).
- `ADDR_W` is derived: `CNT_W+1`. Bit `[CNT_W]` is the ping-pong bank bit.

Ports:
- `clk`  in  1  pipeline clock
- `res`  in  1  reset; asynchronous, active-high
- `cntr_ld_en`  in  1  load `cnt_in` into the count register
- `start_proc`  in  1  start processing the loaded crossing
- `cnt_in`  in  `CNT_W`  tracklet count from the input FIFO
- `dn_afull`  in  1  downstream almost full; suspends read issue
- `proc_bsy`  out  1  crossing in progress
- `mem_rd_en`  out  1  tracklet memory read strobe
- `mem_rd_addr`  out  `ADDR_W`  `{bank, idx}`
- `trk_vld`  out  1  tracklet data valid; aligned with memory read data
- `trk_last`  out  1  qualifies the last `trk_vld` of the crossing
- `cross_done`  out  1  one-cycle end-of-crossing pulse
- `cross_empty`  out  1  qualifies `cross_done`: the crossing had zero tracklets
- `ovr_err`  out  1  sticky protocol error

Behaviour:
- Reset: all outputs are 0; state is IDLE; `bank`, `idx` and `cnt_reg` are 0. Reset mid-crossing aborts immediately, and in-flight `trk_vld` are flushed (the delay line is cleared).
- All outputs are registered.
- Count load: `cntr_ld_en` in IDLE latches `cnt_in`. If `start_proc` arrives in the same cycle, that cycle's `cnt_in` is used, otherwise `cnt_reg`.
- States:
  - IDLE: `start_proc` at cycle T moves to RUN; `proc_bsy`=1 from T+1.
  - RUN: if `idx == cnt`, go to DRAIN. Else, if `dn_afull` is 0, issue a read with `mem_rd_addr={bank,idx}`, `mem_rd_en`=1 (visible the next cycle), and increment `idx`. If `dn_afull`=1, issue nothing and hold.
  - DRAIN: wait until the `RD_LAT` delay line is empty, then go to DONE.
  - DONE: `cross_done`=1 for one cycle, toggle `bank`, clear `idx`, go to IDLE. `proc_bsy` drops the cycle after `cross_done`.
- Timing, no stall, N>0:
  - `mem_rd_en` is high on cycles T+2 … T+N+1.
  - `trk_vld` is `mem_rd_en` delayed `RD_LAT` cycles.
  - `trk_last` is the delayed flag for the read with `idx == N-1`.
  - `cross_done` fires the cycle after the last `trk_vld`.
- N=0: no reads and no `trk_vld`. `cross_done`=1 and `cross_empty`=1 at T+2; `proc_bsy` is low at T+3.
- `dn_afull` takes effect on the issue decision in the cycle it is sampled. Reads already issued still complete, so downstream must reserve at least `RD_LAT`+1 slots.
- `idx` never wraps within a crossing. The maximum count is 2^`CNT_W`-1.
- Protocol errors set `ovr_err`:
  - `start_proc` or `cntr_ld_en` while `proc_bsy` is high or the state is not IDLE. The pulse is otherwise ignored.
  - `ovr_err` is cleared only by `res`.
- A `cntr_ld_en` arriving on the `cross_done` cycle is an error. A `cntr_ld_en` arriving once IDLE is re-entered is accepted.

Decomposition:
- Package `tp_pkg`: state encoding for IDLE/RUN/DRAIN/DONE, `CNT_W` and `RD_LAT` defaults, and the `ADDR_W` derivation.
- One sub-module, `tp_vld_delay`: a parameterised `RD_LAT`-stage shift register for `{vld,last}`, with asynchronous clear and an `empty` output used by DRAIN.

Test Plan:
- Single cycle with `cntr_ld_en` and `start_proc` at T, `cnt_in`=3, `RD_LAT`=2, `dn_afull`=0 -> `mem_rd_en` at T+2..T+4 with addr 0,1,2; `trk_vld` at T+4..T+6, `trk_last` at T+6; `cross_done` at T+7; `proc_bsy` high T+1..T+7, low T+8.
- `cnt_in`=0 -> no `mem_rd_en`; `cross_done`=1 and `cross_empty`=1 at T+2; `proc_bsy` low at T+3; `bank` toggles.
- Two back-to-back crossings, counts 2 then 1 -> second crossing addresses are 0x100 and up (`bank`=1); third crossing returns to `bank`=0.
- `cnt_in`=4 with `dn_afull`=1 for 3 cycles after the second read -> exactly 4 reads at addresses 0..3 with a 3-cycle gap; `trk_last` only on the 4th `trk_vld`.
- `start_proc` pulsed in RUN -> `ovr_err`=1 and stays 1; the current crossing completes unchanged.
- `res` asserted in RUN with reads in flight -> all outputs 0 asynchronously; no `trk_vld` after release; the next crossing starts at `bank` 0.
